// File: rtl/wb_ooo_slave_mem_pkg.sv
// Shared types for the out-of-order Wishbone slave memory.
//   DELAY_W      width of the per-request response delay
//   ooo_entry_t  one tag-table slot {vld, tag, data, cnt}
//   term_t       registered bus termination for the current request
package wb_ooo_pkg;

  localparam int DELAY_W = 4;
  localparam int ADR_W   = 64;
  localparam int DAT_W   = 64;
  localparam int SEL_W   = 8;
  localparam int TAG_W   = 16;

  typedef struct packed {
    logic               vld;
    logic [TAG_W-1:0]   tag;
    logic [DAT_W-1:0]   data;
    logic [DELAY_W-1:0] cnt;
  } ooo_entry_t;

  typedef enum logic [1:0] {
    TERM_NONE,
    TERM_ACK,
    TERM_ERR,
    TERM_RTY
  } term_t;

  // Saturate a requested delay at the configured maximum.
  function automatic logic [DELAY_W-1:0] clip_delay(input logic [DELAY_W-1:0] d,
                                                    input int max_d);
    return (int'(d) > max_d) ? DELAY_W'(max_d) : d;
  endfunction

endpackage

// File: rtl/wb_ooo_slave_mem_if.sv
// Bus bundle between an out-of-order Wishbone master and the slave memory.
//   Request : CYC_I STB_I WE_I ADR_I DAT_I SEL_I TGA_I TGC_I TGD_I LOCK_I RST_I
//   Term    : ACK_O ERR_O RTY_O (one-cycle pulses)
//   Response: RESP_O DAT_O TGD_O (one beat per accepted request)
interface wb_ooo_slave_mem_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic [63:0] ADR_I;
  logic [63:0] DAT_I;
  logic [7:0]  SEL_I;
  logic [15:0] TGA_I;
  logic [15:0] TGC_I;
  logic [15:0] TGD_I;
  logic        LOCK_I;
  logic        RST_I;
  logic        ACK_O;
  logic        ERR_O;
  logic        RTY_O;
  logic        RESP_O;
  logic [63:0] DAT_O;
  logic [15:0] TGD_O;

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, TGD_I, LOCK_I, RST_I,
    output ACK_O, ERR_O, RTY_O, RESP_O, DAT_O, TGD_O
  );

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I, TGD_I, LOCK_I, RST_I,
    input  ACK_O, ERR_O, RTY_O, RESP_O, DAT_O, TGD_O
  );
endinterface

// File: rtl/wb_ooo_tag_table.sv
// Outstanding-request table: allocation into the lowest free slot, per-slot
// countdown, and lowest-index ready-select onto a registered response beat.
//   clk, rst      clock, synchronous active-high reset
//   alloc_i       write {tag,data,cnt} into the lowest free slot this edge
//   full_o        all slots valid (registered view)
//   resp_o        registered response beat, with resp_tag_o / resp_data_o
module wb_ooo_tag_table
  import wb_ooo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_i,
  input  logic [TAG_W-1:0]   alloc_tag_i,
  input  logic [DAT_W-1:0]   alloc_data_i,
  input  logic [DELAY_W-1:0] alloc_cnt_i,
  output logic               full_o,
  output logic               resp_o,
  output logic [TAG_W-1:0]   resp_tag_o,
  output logic [DAT_W-1:0]   resp_data_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ooo_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]       vld, rdy;
  logic [IW-1:0]          free_idx, rdy_idx;
  logic                   free_ok, rdy_ok;
  logic                   resp_q, resp_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [DAT_W-1:0]       data_q, data_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign vld[g] = ent_q[g].vld;
    assign rdy[g] = ent_q[g].vld && (ent_q[g].cnt == '0);
  end

  assign full_o = &vld;

  // Downward scans so the lowest matching index is the last one written.
  always_comb begin
    free_idx = '0;
    free_ok  = 1'b0;
    rdy_idx  = '0;
    rdy_ok   = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!vld[i]) begin
        free_idx = IW'(i);
        free_ok  = 1'b1;
      end
      if (rdy[i]) begin
        rdy_idx = IW'(i);
        rdy_ok  = 1'b1;
      end
    end
  end

  // Free and alloc never collide: a free slot has vld=0, a ready slot vld=1,
  // so a slot released at this edge is only allocatable from the next one.
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++)
      if (ent_q[i].vld && (ent_q[i].cnt != '0))
        ent_d[i].cnt = ent_q[i].cnt - 1'b1;
    if (rdy_ok)
      ent_d[rdy_idx] = '0;
    if (alloc_i && free_ok)
      ent_d[free_idx] = '{vld: 1'b1, tag: alloc_tag_i, data: alloc_data_i, cnt: alloc_cnt_i};
  end

  always_comb begin
    resp_d = rdy_ok;
    tag_d  = rdy_ok ? ent_q[rdy_idx].tag  : '0;
    data_d = rdy_ok ? ent_q[rdy_idx].data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= '0;
      resp_q <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      ent_q  <= ent_d;
      resp_q <= resp_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign resp_o      = resp_q;
  assign resp_tag_o  = tag_q;
  assign resp_data_o = data_q;

endmodule

// File: rtl/wb_ooo_slave_mem.sv
// Wishbone slave memory with out-of-order, tag-matched response beats.
// Each request gets one registered termination (ACK/ERR/RTY); ACKed requests
// later return one RESP_O beat carrying their tag after a per-request delay.
//   clk, rst  clock, synchronous active-high reset (memory is not reset)
//   bus       slave side of wb_ooo_slave_mem_if
module wb_ooo_slave_mem
  import wb_ooo_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int DEPTH     = 8,
  parameter int MAX_DELAY = 15
) (
  input  logic               clk,
  input  logic               rst,
  wb_ooo_slave_mem_if.slave  bus
);

  localparam int MW = $clog2(MEM_WORDS);

  term_t              term_q, term_d;
  logic               req, in_range, full, alloc;
  logic [MW-1:0]      widx;
  logic [DAT_W-1:0]   snap;
  logic [DELAY_W-1:0] dly;
  logic [DAT_W-1:0]   mem_q [MEM_WORDS];

  // A termination pulse in flight blocks the next accept, so a master holding
  // STB across the pulse is not accepted twice.
  assign req      = bus.CYC_I && bus.STB_I && (term_q == TERM_NONE);
  assign in_range = bus.ADR_I[63:3] < 61'(MEM_WORDS);
  assign widx     = bus.ADR_I[MW+2:3];
  assign dly      = clip_delay(bus.TGC_I[DELAY_W-1:0], MAX_DELAY);

  always_comb begin
    term_d = TERM_NONE;
    if (req) begin
      if (!in_range)  term_d = TERM_ERR;
      else if (full)  term_d = TERM_RTY;
      else            term_d = TERM_ACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) term_q <= TERM_NONE;
    else     term_q <= term_d;
  end

  assign alloc = (term_d == TERM_ACK) && !rst;

  always_ff @(posedge clk) begin
    if (alloc && bus.WE_I)
      for (int b = 0; b < SEL_W; b++)
        if (bus.SEL_I[b]) mem_q[widx][b*8 +: 8] <= bus.DAT_I[b*8 +: 8];
  end

  // Reads capture the word at accept time; writes respond with zero data.
  assign snap = bus.WE_I ? '0 : mem_q[widx];

  wb_ooo_tag_table #(.DEPTH(DEPTH)) u_tbl (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (alloc),
    .alloc_tag_i (bus.TGA_I),
    .alloc_data_i(snap),
    .alloc_cnt_i (dly),
    .full_o      (full),
    .resp_o      (bus.RESP_O),
    .resp_tag_o  (bus.TGD_O),
    .resp_data_o (bus.DAT_O)
  );

  assign bus.ACK_O = (term_q == TERM_ACK);
  assign bus.ERR_O = (term_q == TERM_ERR);
  assign bus.RTY_O = (term_q == TERM_RTY);

  logic unused_bits;
  assign unused_bits = ^{bus.ADR_I[2:0], bus.TGC_I[15:DELAY_W], bus.TGD_I,
                         bus.LOCK_I, bus.RST_I};

endmodule
